// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and writeback-source encoding for the register-file writeback path
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way ALU/LSU writeback arbiter, round-robin or fixed ALU-first
module rr_arb2
  import regfile_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic alu_req,
  input  logic lsu_req,
  output logic alu_gnt,
  output logic lsu_gnt
);
  wb_src_e last_gnt;
  // ALU wins when alone, in fixed mode, or when LSU was served last
  always_comb begin
    alu_gnt = alu_req & (!lsu_req | !RR_EN | (last_gnt == WB_SRC_LSU));
    lsu_gnt = lsu_req & !alu_gnt;
  end
  // pointer moves only when a grant (and therefore a transfer) happens
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) last_gnt <= WB_SRC_LSU;
    else if (alu_gnt) last_gnt <= WB_SRC_ALU;
    else if (lsu_gnt) last_gnt <= WB_SRC_LSU;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/LSU writebacks into one registered write port and tracks pending writes
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_iss_valid,
  input  logic [REG_ADDR_W-1:0] i_iss_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_iss_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_iss_rd_addr,
  output logic                  o_iss_stall,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
  input  logic [XLEN-1:0]       i_alu_rd_data,
  output logic                  o_alu_ready,
  input  logic                  i_lsu_valid,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd_addr,
  input  logic [XLEN-1:0]       i_lsu_rd_data,
  output logic                  o_lsu_ready,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic                  o_rd_wren,
  output logic [NUM_REGS-1:0]   o_pending
);
  logic                  xfer;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic [NUM_REGS-1:0]   pend_nz, set_vec, clr_vec;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .alu_req  (i_alu_valid),
    .lsu_req  (i_lsu_valid),
    .alu_gnt  (o_alu_ready),
    .lsu_gnt  (o_lsu_ready)
  );

  // select the granted request and form scoreboard set/clear masks; x0 never counts as pending
  always_comb begin
    xfer = o_alu_ready | o_lsu_ready;
    wb_addr = o_alu_ready ? i_alu_rd_addr : i_lsu_rd_addr;
    wb_data = o_alu_ready ? i_alu_rd_data : i_lsu_rd_data;
    pend_nz = {o_pending[NUM_REGS-1:1], 1'b0};
    o_iss_stall = i_iss_valid & (pend_nz[i_iss_rs1_addr] | pend_nz[i_iss_rs2_addr] | pend_nz[i_iss_rd_addr]);
    set_vec = (i_iss_valid && !o_iss_stall && i_iss_rd_addr != '0) ? (NUM_REGS'(1) << i_iss_rd_addr) : '0;
    clr_vec = o_rd_wren ? (NUM_REGS'(1) << o_rd_addr) : '0;
  end

  // registered write port; writes to x0 are accepted but never enabled
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= xfer && (wb_addr != '0);
      if (xfer) begin
        o_rd_addr <= wb_addr;
        o_rd_data <= wb_data;
      end
    end

  // pending scoreboard; a set on the same edge as a clear keeps the bit
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) o_pending <= '0;
    else o_pending <= (o_pending & ~clr_vec) | set_vec;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scoreboard bench for regfile_wb_ctrl in round-robin and fixed-priority modes
module tb_regfile_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, alu_valid_fp = 1'b0, lsu_valid_fp = 1'b0;
  logic [4:0]  alu_addr = '0, lsu_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        stall, alu_rdy, lsu_rdy, wren;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, pending;
  logic        stall_fp, alu_rdy_fp, lsu_rdy_fp, wren_fp;
  logic [4:0]  wb_addr_fp;
  logic [31:0] wb_data_fp, pending_fp;
  logic [36:0] exp_q[$], fp_q[$];
  logic [36:0] e;
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.RR_EN(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_iss_valid(iss_valid), .i_iss_rs1_addr(rs1), .i_iss_rs2_addr(rs2), .i_iss_rd_addr(rd),
    .o_iss_stall(stall),
    .i_alu_valid(alu_valid), .i_alu_rd_addr(alu_addr), .i_alu_rd_data(alu_data), .o_alu_ready(alu_rdy),
    .i_lsu_valid(lsu_valid), .i_lsu_rd_addr(lsu_addr), .i_lsu_rd_data(lsu_data), .o_lsu_ready(lsu_rdy),
    .o_rd_addr(wb_addr), .o_rd_data(wb_data), .o_rd_wren(wren), .o_pending(pending)
  );

  regfile_wb_ctrl #(.RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_iss_valid(iss_valid), .i_iss_rs1_addr(rs1), .i_iss_rs2_addr(rs2), .i_iss_rd_addr(rd),
    .o_iss_stall(stall_fp),
    .i_alu_valid(alu_valid_fp), .i_alu_rd_addr(alu_addr), .i_alu_rd_data(alu_data), .o_alu_ready(alu_rdy_fp),
    .i_lsu_valid(lsu_valid_fp), .i_lsu_rd_addr(lsu_addr), .i_lsu_rd_data(lsu_data), .o_lsu_ready(lsu_rdy_fp),
    .o_rd_addr(wb_addr_fp), .o_rd_data(wb_data_fp), .o_rd_wren(wren_fp), .o_pending(pending_fp)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    alu_valid_fp = 1'b0;
    lsu_valid_fp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // monitor: every presented write must match the oldest expected write
  always @(negedge clk)
    if (rst_n) begin
      if (wren) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL wb_unexpected: got addr %0d data %h, expected no write", wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rr", {27'b0, wb_addr, wb_data}, {27'b0, e});
        end
      end
      if (wren_fp) begin
        if (fp_q.size() == 0) begin
          checks++;
          $display("FAIL wb_fp_unexpected: got addr %0d data %h, expected no write", wb_addr_fp, wb_data_fp);
        end else begin
          e = fp_q.pop_front();
          chk("wb_fp", {27'b0, wb_addr_fp, wb_data_fp}, {27'b0, e});
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    smp();
    chk("rst_pending", pending, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_data", wb_data, 0);
    // hazard stall on x5 until its writeback clears the scoreboard
    do_reset();
    iss_valid = 1; rd = 5; rs1 = 1; rs2 = 2;
    smp(); chk("iss_free", stall, 0);
    cyc(); rs1 = 5; rs2 = 0; rd = 6;
    smp(); chk("pend_x5", pending, 32'h20); chk("stall_rs1", stall, 1);
    cyc(); alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; exp_q.push_back({5'd5, 32'hDEADBEEF});
    smp(); chk("alu_rdy_solo", alu_rdy, 1); chk("stall_hold", stall, 1);
    cyc(); alu_valid = 0;
    smp(); chk("stall_wren_cyc", stall, 1); chk("wren_x5", wren, 1);
    cyc();
    smp(); chk("stall_clear", stall, 0); chk("pend_clear", pending, 0);
    cyc(); iss_valid = 0;
    smp(); chk("pend_x6", pending, 32'h40);
    // round-robin tie: ALU, then LSU, then ALU alone
    do_reset();
    alu_valid = 1; alu_addr = 3; alu_data = 32'h11; lsu_valid = 1; lsu_addr = 4; lsu_data = 32'h22;
    exp_q.push_back({5'd3, 32'h11});
    smp(); chk("rr1_alu", alu_rdy, 1); chk("rr1_lsu", lsu_rdy, 0);
    cyc(); exp_q.push_back({5'd4, 32'h22});
    smp(); chk("rr2_alu", alu_rdy, 0); chk("rr2_lsu", lsu_rdy, 1);
    cyc(); lsu_valid = 0; exp_q.push_back({5'd3, 32'h11});
    smp(); chk("rr3_alu", alu_rdy, 1); chk("rr3_wren", wren, 1);
    cyc(); alu_valid = 0;
    smp();
    cyc();
    smp(); chk("idle_wren", wren, 0); chk("rr_pending", pending, 0);
    // fixed priority: LSU starves while ALU keeps requesting
    do_reset();
    alu_addr = 3; alu_data = 32'h11; lsu_addr = 4; lsu_data = 32'h22;
    alu_valid_fp = 1; lsu_valid_fp = 1;
    for (int i = 0; i < 3; i++) begin
      fp_q.push_back({5'd3, 32'h11});
      smp(); chk("fp_alu", alu_rdy_fp, 1); chk("fp_lsu", lsu_rdy_fp, 0);
      cyc();
    end
    alu_valid_fp = 0; fp_q.push_back({5'd4, 32'h22});
    smp(); chk("fp_lsu_last", lsu_rdy_fp, 1);
    cyc(); lsu_valid_fp = 0;
    repeat (2) cyc();
    // write to x0 is accepted but never reaches the port
    do_reset();
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'hFFFFFFFF;
    smp(); chk("x0_rdy", lsu_rdy, 1);
    cyc(); lsu_valid = 0;
    smp(); chk("x0_wren", wren, 0); chk("x0_pending", pending, 0);
    // issue rd=7 while x7 is being written: set wins
    do_reset();
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77; exp_q.push_back({5'd7, 32'h77});
    cyc(); alu_valid = 0; iss_valid = 1; rd = 7; rs1 = 0; rs2 = 0;
    smp(); chk("sw_wren", wren, 1); chk("sw_stall", stall, 0);
    cyc(); iss_valid = 0;
    smp(); chk("sw_pending", pending, 32'h80);
    // asynchronous reset mid-cycle discards a pending write
    do_reset();
    iss_valid = 1; rs1 = 0; rs2 = 0;
    for (int r = 4; r < 8; r++) begin
      rd = 5'(r);
      cyc();
    end
    iss_valid = 0;
    alu_valid = 1; alu_addr = 1; alu_data = 32'h1234;
    cyc(); alu_valid = 0;
    #2;
    chk("ar_pre_pending", pending, 32'hF0); chk("ar_pre_wren", wren, 1);
    rst_n = 0;
    #1;
    chk("ar_wren", wren, 0); chk("ar_pending", pending, 0);
    chk("ar_addr", wb_addr, 0); chk("ar_data", wb_data, 0);
    // ready follows valid during reset but nothing transfers; first edge after release does
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h99;
    #1 chk("inrst_rdy", lsu_rdy, 1);
    cyc();
    chk("inrst_wren", wren, 0); chk("inrst_pending", pending, 0);
    rst_n = 1; exp_q.push_back({5'd9, 32'h99});
    cyc(); lsu_valid = 0;
    smp(); chk("post_rst_wren", wren, 1);
    repeat (2) cyc();
    chk("drain_rr", exp_q.size(), 0);
    chk("drain_fp", fp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
